conv_stream_engine: RTL and testbench
=====================================

// Module: conv_stream_engine
// PURPOSE
//  Parametrised streaming 1-D valid convolution: y[n] = sum_k x[n+k]*f[k], n=0..NOUT-1, NOUT=LENX-LENF+1.
//  Successor to the fixed-ROM conv_<X>_<F>_<W>_<P> cores: filter is loadable at run time (stream port),
//  P MAC lanes are a parameter, and ReLU is optional. Sits between the input sample stream and the output stream.
// PARAMETERS
//  WIDTH   16  sample/coeff/result width, signed two's complement
//  LENX    64  input vector length (>= LENF)
//  LENF    33  filter length (>= 2)
//  P        2  parallel MAC lanes, 1..NOUT
//  RELU     1  1: clamp negative results to 0; 0: pass signed saturated result
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  s_data_f     in   WIDTH  filter coefficient, f[0] first
//  s_valid_f    in   1      coefficient valid
//  s_ready_f    out  1      coefficient accepted when s_valid_f & s_ready_f
//  s_data_x     in   WIDTH  input sample, x[0] first
//  s_valid_x    in   1      sample valid
//  s_ready_x    out  1      sample accepted when s_valid_x & s_ready_x
//  m_data_y     out  WIDTH  output sample, y[0] first
//  m_valid_y    out  1      output valid; held with stable data until m_ready_y
//  m_ready_y    in   1      downstream ready
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; f_loaded=0; counters 0. X/F memories not cleared (contents don't-care).
//  States: IDLE -> LOAD_F (s_valid_f & s_ready_f on f[0]) -> IDLE after f[LENF-1]; sets f_loaded=1.
//          IDLE -> LOAD_X (first x beat, only if f_loaded) -> MAC after x[LENX-1] accepted
//          MAC -> OUT after group computed -> MAC (next group) or IDLE (after y[NOUT-1] handshaked).
//  s_ready_f = 1 only in IDLE and LOAD_F; in IDLE s_valid_f takes priority over s_valid_x in the same cycle.
//  s_ready_x = 1 only in LOAD_X, or in IDLE with f_loaded=1 and s_valid_f=0. Before first filter load x is stalled.
//  A new filter may be loaded between vectors only; partial filter load blocks x until complete.
//  Group g computes y[gP .. gP+P-1]. Lane l reads x[gP+l+k] from its own X copy, f[k] from shared F RAM.
//  MAC: 1-cycle sync RAM read; k=0..LENF-1 issued on consecutive cycles; accumulator cleared at group start.
//   product 2*WIDTH, saturated to WIDTH; sum = acc + sat(product) in WIDTH+1 bits, saturated to WIDTH.
//   Saturation limits: +2^(WIDTH-1)-1, -2^(WIDTH-1). RELU applied after final accumulation only.
//  Latency: first m_valid_y exactly LENF+2 cycles after MAC entry; lanes then emitted in order l=0..P-1,
//   one per m_valid_y & m_ready_y; next group's MAC starts the cycle after the last lane handshake.
//  Tail group: lanes with gP+l >= NOUT are not read, not emitted; exactly NOUT outputs per vector.
//  Lane x addresses never exceed LENX-1 (out-of-range lanes are gated, not wrapped).
//  m_valid_y never deasserts without handshake; m_data_y stable while m_valid_y & !m_ready_y.
//  Reset mid-operation: aborts current vector/filter load; next vector requires a fresh filter load.
// STRUCTURE
//  Package conv_stream_pkg: state_t enum {IDLE,LOAD_F,LOAD_X,MAC,OUT}; function sat_w(logic signed [..]);
//   localparams NOUT, NGRP=ceil(NOUT/P), AW=$clog2(LENX), FW=$clog2(LENF).
//  Sub-module conv_mac_lane (saturating MAC + accumulator + RELU), instantiated P times via generate.
//  Top: FSM, x/f write counters, group/k counters, P x-RAM copies (write-broadcast), 1 f-RAM, output mux.
// TESTING (WIDTH=8, LENX=8, LENF=4, P=2, NOUT=5 unless noted)
//  1 f={1,1,1,1}, x=1..8, m_ready_y=1 -> y = 10,14,18,22,26; first m_valid_y LENF+2=6 cycles after MAC entry.
//  2 f={127,127,127,127}, x all 127 -> all y=127; f all 127, x all -128, RELU=0 -> all y=-128; RELU=1 -> 0.
//  3 f={-1,0,0,0}, x=1..8: RELU=1 -> 0,0,0,0,0; RELU=0 -> -1,-2,-3,-4,-5.
//  4 P=3 (NOUT=5, tail group 2 lanes), test 1 stimulus -> exactly 5 outputs, no extra m_valid_y.
//  5 Random s_valid_x/s_valid_f/m_ready_y, 200 vectors, filter reloaded every 10 vectors -> match C model, 0 errors.
//  6 Reset asserted mid-MAC -> outputs 0 next cycle; x stalled (s_ready_x=0) until new filter; then test 1 passes.

Source files
------------

// File: rtl/conv_stream_engine_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
package conv_stream_engine_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_F = 3'd1,
    LOAD_X = 3'd2,
    MAC    = 3'd3,
    OUT    = 3'd4
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Minimum one bit, so single-entry counters still have a legal width.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// Filter, sample and result streams of the convolution engine as one bundle.
interface conv_stream_engine_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] s_data_f;
  logic                    s_valid_f;
  logic                    s_ready_f;
  logic signed [WIDTH-1:0] s_data_x;
  logic                    s_valid_x;
  logic                    s_ready_x;
  logic signed [WIDTH-1:0] m_data_y;
  logic                    m_valid_y;
  logic                    m_ready_y;

  modport master (
    output s_data_f, s_valid_f, s_data_x, s_valid_x, m_ready_y,
    input  s_ready_f, s_ready_x, m_data_y, m_valid_y
  );

  modport slave (
    input  s_data_f, s_valid_f, s_data_x, s_valid_x, m_ready_y,
    output s_ready_f, s_ready_x, m_data_y, m_valid_y
  );
endinterface

// File: rtl/conv_mac_lane.sv
// One MAC lane: saturated product register, saturating accumulator, optional ReLU.
module conv_mac_lane #(
  parameter int WIDTH = 16,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    mul_en_i,
  input  logic                    acc_en_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] f_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [WIDTH-1:0]   prod_sat;
  logic signed [WIDTH-1:0]   prod_q;
  logic signed [WIDTH-1:0]   acc_q;
  logic signed [WIDTH-1:0]   acc_d;
  logic        [WIDTH:0]     sum;

  assign prod_full = x_i * f_i;

  // A value fits in WIDTH bits when its top WIDTH+1 bits are all sign copies.
  always_comb begin
    prod_sat = prod_full[WIDTH-1:0];
    if (prod_full[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_full[2*WIDTH-1]}})
      prod_sat = prod_full[2*WIDTH-1] ? MINV : MAXV;
    sum   = {acc_q[WIDTH-1], acc_q} + {prod_q[WIDTH-1], prod_q};
    acc_d = sum[WIDTH-1:0];
    if (sum[WIDTH] != sum[WIDTH-1])
      acc_d = sum[WIDTH] ? MINV : MAXV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) prod_q <= prod_sat;
      if (clr_i) acc_q <= '0;
      else if (acc_en_i) acc_q <= acc_d;
    end
  end

  assign y_o = ((RELU != 0) && acc_q[WIDTH-1]) ? '0 : acc_q;

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming 1-D valid convolution with run-time loadable filter and P parallel MAC lanes.
// state  | meaning
// IDLE   | waiting for a filter load or (once a filter is loaded) the first sample
// LOAD_F | accepting f[1..LENF-1]
// LOAD_X | accepting x[1..LENX-1]
// MAC    | reading RAMs and accumulating one group of P outputs
// OUT    | presenting the group's valid lanes in order
module conv_stream_engine
  import conv_stream_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int P     = 2,
  parameter int RELU  = 1
) (
  input logic                 clk,
  input logic                 reset,
  conv_stream_engine_if.slave bus
);

  localparam int NOUT = LENX - LENF + 1;
  localparam int NGRP = ceil_div(NOUT, P);
  localparam int AW   = bits_for(LENX);
  localparam int FW   = bits_for(LENF);
  localparam int CYW  = bits_for(LENF + 2);
  localparam int LW   = bits_for(P);
  localparam int GW   = bits_for(NGRP);

  state_t          state_q, state_d;
  logic            f_loaded_q, f_loaded_d;
  logic [FW-1:0]   f_cnt_q, f_cnt_d;
  logic [AW-1:0]   x_cnt_q, x_cnt_d;
  logic [CYW-1:0]  cyc_q, cyc_d;
  logic [AW-1:0]   base_q, base_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [LW-1:0]   lane_q, lane_d;

  logic signed [WIDTH-1:0] f_mem [LENF];
  logic signed [WIDTH-1:0] x_mem [P][LENX];
  logic signed [WIDTH-1:0] f_rd_q;
  logic signed [WIDTH-1:0] lane_y [P];
  logic signed [WIDTH-1:0] m_data;
  logic [P-1:0]            lane_act;
  logic [AW-1:0]           x_addr [P];

  logic s_ready_f, s_ready_x, f_fire, x_fire;
  logic rd_en, mac_clr, mac_mul, mac_acc, lane_last;

  // x waits for the filter, and a pending coefficient wins the IDLE arbitration.
  assign s_ready_f = !reset && ((state_q == IDLE) || (state_q == LOAD_F));
  assign s_ready_x = !reset && ((state_q == LOAD_X) ||
                     ((state_q == IDLE) && f_loaded_q && !bus.s_valid_f));
  assign f_fire    = bus.s_valid_f && s_ready_f;
  assign x_fire    = bus.s_valid_x && s_ready_x;

  // Pipeline: read at cycle c, product at c+1, accumulate at c+2.
  assign rd_en   = (state_q == MAC) && (cyc_q < CYW'(LENF));
  assign mac_clr = (state_q == MAC) && (cyc_q == '0);
  assign mac_mul = (state_q == MAC) && (cyc_q != '0) && (cyc_q <= CYW'(LENF));
  assign mac_acc = (state_q == MAC) && (cyc_q >= CYW'(2));

  always_comb begin
    for (int l = 0; l < P; l++) begin
      lane_act[l] = (int'(base_q) + l) < NOUT;
      x_addr[l]   = base_q + AW'(l) + AW'(cyc_q);
    end
  end

  assign lane_last = (lane_q == LW'(P - 1)) || ((int'(base_q) + int'(lane_q) + 1) >= NOUT);

  always_ff @(posedge clk) begin
    if (f_fire) f_mem[f_cnt_q] <= bus.s_data_f;
    if (rd_en) f_rd_q <= f_mem[cyc_q[FW-1:0]];
  end

  // Every lane keeps its own sample copy so all lanes read in the same cycle.
  always_ff @(posedge clk) begin
    for (int l = 0; l < P; l++)
      if (x_fire) x_mem[l][x_cnt_q] <= bus.s_data_x;
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic signed [WIDTH-1:0] x_rd_q;

    always_ff @(posedge clk) begin
      if (rd_en && lane_act[l]) x_rd_q <= x_mem[l][x_addr[l]];
    end

    conv_mac_lane #(
      .WIDTH (WIDTH),
      .RELU  (RELU)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (mac_clr),
      .mul_en_i (mac_mul),
      .acc_en_i (mac_acc),
      .x_i      (x_rd_q),
      .f_i      (f_rd_q),
      .y_o      (lane_y[l])
    );
  end

  always_comb begin
    state_d    = state_q;
    f_loaded_d = f_loaded_q;
    f_cnt_d    = f_cnt_q;
    x_cnt_d    = x_cnt_q;
    cyc_d      = cyc_q;
    base_d     = base_q;
    grp_d      = grp_q;
    lane_d     = lane_q;
    case (state_q)
      IDLE: begin
        if (f_fire) begin
          state_d = LOAD_F;
          f_cnt_d = FW'(1);
        end else if (x_fire) begin
          state_d = LOAD_X;
          x_cnt_d = AW'(1);
        end
      end
      LOAD_F: begin
        if (f_fire) begin
          if (f_cnt_q == FW'(LENF - 1)) begin
            state_d    = IDLE;
            f_cnt_d    = '0;
            f_loaded_d = 1'b1;
          end else begin
            f_cnt_d = f_cnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (x_fire) begin
          if (x_cnt_q == AW'(LENX - 1)) begin
            state_d = MAC;
            x_cnt_d = '0;
            cyc_d   = '0;
            base_d  = '0;
            grp_d   = '0;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
      end
      MAC: begin
        if (cyc_q == CYW'(LENF + 1)) begin
          state_d = OUT;
          lane_d  = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.m_ready_y) begin
          if (lane_last) begin
            if (grp_q == GW'(NGRP - 1)) begin
              state_d = IDLE;
            end else begin
              state_d = MAC;
              cyc_d   = '0;
              base_d  = base_q + AW'(P);
              grp_d   = grp_q + 1'b1;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      f_loaded_q <= 1'b0;
      f_cnt_q    <= '0;
      x_cnt_q    <= '0;
      cyc_q      <= '0;
      base_q     <= '0;
      grp_q      <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      f_loaded_q <= f_loaded_d;
      f_cnt_q    <= f_cnt_d;
      x_cnt_q    <= x_cnt_d;
      cyc_q      <= cyc_d;
      base_q     <= base_d;
      grp_q      <= grp_d;
      lane_q     <= lane_d;
    end
  end

  always_comb begin
    m_data = '0;
    if (state_q == OUT) m_data = lane_y[lane_q];
  end

  assign bus.s_ready_f = s_ready_f;
  assign bus.s_ready_x = s_ready_x;
  assign bus.m_valid_y = (state_q == OUT);
  assign bus.m_data_y  = m_data;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench: two engines (P=2/ReLU and P=3/no ReLU) share the same stimulus.
module tb_conv_stream_engine;

  localparam int W  = 8;
  localparam int LX = 8;
  localparam int LF = 4;
  localparam int NO = LX - LF + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_stream_engine_if #(.WIDTH(W)) ifa ();
  conv_stream_engine_if #(.WIDTH(W)) ifb ();

  conv_stream_engine #(.WIDTH(W), .LENX(LX), .LENF(LF), .P(2), .RELU(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  conv_stream_engine #(.WIDTH(W), .LENX(LX), .LENF(LF), .P(3), .RELU(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];
  bit rnd_ready = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: same saturation points as the engine, ReLU only at the end.
  function automatic void push_model(input int f[8], input int x[8]);
    for (int n = 0; n < NO; n++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < LF; k++) acc = sat8(acc + sat8(x[n+k] * f[k]));
      qa.push_back(acc < 0 ? 0 : acc);
      qb.push_back(acc);
    end
  endfunction

  function automatic void push_exp(input int ea[5], input int eb[5]);
    for (int i = 0; i < NO; i++) begin
      qa.push_back(ea[i]);
      qb.push_back(eb[i]);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    ifa.m_ready_y = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ifb.m_ready_y = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int na = 0, xa_cnt = 0, xa_neg = 0, hold_da = 0;
  bit lat_a = 0, stall_a = 0;
  always @(negedge clk) begin
    na++;
    if (reset) begin
      xa_cnt = 0; lat_a = 0; stall_a = 0;
    end else begin
      if (stall_a) begin
        chk("hold_valid_a", int'(ifa.m_valid_y), 1);
        chk("hold_data_a", int'(ifa.m_data_y), hold_da);
      end
      if (ifa.m_valid_y && lat_a) begin
        chk("latency_a", na - xa_neg, LF + 3);
        lat_a = 0;
      end
      if (ifa.m_valid_y && ifa.m_ready_y) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_y_a: got %0d expected no output", int'(ifa.m_data_y));
        end else chk("y_a", int'(ifa.m_data_y), qa.pop_front());
      end
      stall_a = ifa.m_valid_y && !ifa.m_ready_y;
      hold_da = int'(ifa.m_data_y);
      if (ifa.s_valid_x && ifa.s_ready_x) begin
        xa_cnt++;
        if (xa_cnt == LX) begin xa_cnt = 0; xa_neg = na; lat_a = 1; end
      end
    end
  end

  int nb = 0, xb_cnt = 0, xb_neg = 0, hold_db = 0;
  bit lat_b = 0, stall_b = 0;
  always @(negedge clk) begin
    nb++;
    if (reset) begin
      xb_cnt = 0; lat_b = 0; stall_b = 0;
    end else begin
      if (stall_b) begin
        chk("hold_valid_b", int'(ifb.m_valid_y), 1);
        chk("hold_data_b", int'(ifb.m_data_y), hold_db);
      end
      if (ifb.m_valid_y && lat_b) begin
        chk("latency_b", nb - xb_neg, LF + 3);
        lat_b = 0;
      end
      if (ifb.m_valid_y && ifb.m_ready_y) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_y_b: got %0d expected no output", int'(ifb.m_data_y));
        end else chk("y_b", int'(ifb.m_data_y), qb.pop_front());
      end
      stall_b = ifb.m_valid_y && !ifb.m_ready_y;
      hold_db = int'(ifb.m_data_y);
      if (ifb.s_valid_x && ifb.s_ready_x) begin
        xb_cnt++;
        if (xb_cnt == LX) begin xb_cnt = 0; xb_neg = nb; lat_b = 1; end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with valids dropped.
  task automatic send(input bit is_f, input int n, input int va[8], input bit gaps);
    int ia, ib, idle;
    bit acc_a, acc_b, on;
    ia = 0; ib = 0; idle = 0;
    while ((ia < n || ib < n) && idle < 400) begin
      on = (ia < n) && (!gaps || $urandom_range(0, 3) != 0);
      if (is_f) begin ifa.s_valid_f = on; ifa.s_data_f = W'(va[ia % 8]); end
      else      begin ifa.s_valid_x = on; ifa.s_data_x = W'(va[ia % 8]); end
      on = (ib < n) && (!gaps || $urandom_range(0, 3) != 0);
      if (is_f) begin ifb.s_valid_f = on; ifb.s_data_f = W'(va[ib % 8]); end
      else      begin ifb.s_valid_x = on; ifb.s_data_x = W'(va[ib % 8]); end
      @(negedge clk);
      acc_a = is_f ? (ifa.s_valid_f && ifa.s_ready_f) : (ifa.s_valid_x && ifa.s_ready_x);
      acc_b = is_f ? (ifb.s_valid_f && ifb.s_ready_f) : (ifb.s_valid_x && ifb.s_ready_x);
      @(posedge clk); #1;
      if (acc_a) ia++;
      if (acc_b) ib++;
      idle = (acc_a || acc_b) ? 0 : idle + 1;
    end
    ifa.s_valid_f = 0; ifa.s_valid_x = 0;
    ifb.s_valid_f = 0; ifb.s_valid_x = 0;
    if (idle >= 400) begin
      checks++; errors++;
      $display("FAIL send_timeout: got %0d/%0d beats expected %0d", ia, ib, n);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  int f_one[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  int f_max[8]  = '{127, 127, 127, 127, 0, 0, 0, 0};
  int f_neg[8]  = '{-1, 0, 0, 0, 0, 0, 0, 0};
  int x_ramp[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int x_max[8]  = '{127, 127, 127, 127, 127, 127, 127, 127};
  int x_min[8]  = '{-128, -128, -128, -128, -128, -128, -128, -128};
  int e_t1[5]   = '{10, 14, 18, 22, 26};
  int e_max[5]  = '{127, 127, 127, 127, 127};
  int e_min[5]  = '{-128, -128, -128, -128, -128};
  int e_zero[5] = '{0, 0, 0, 0, 0};
  int e_neg[5]  = '{-1, -2, -3, -4, -5};
  int fr[8], xr[8];

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mvalid_a"}, int'(ifa.m_valid_y), 0);
    chk({tag, "_mdata_a"},  int'(ifa.m_data_y), 0);
    chk({tag, "_xready_a"}, int'(ifa.s_ready_x), 0);
    chk({tag, "_mvalid_b"}, int'(ifb.m_valid_y), 0);
    chk({tag, "_mdata_b"},  int'(ifb.m_data_y), 0);
    chk({tag, "_xready_b"}, int'(ifb.s_ready_x), 0);
  endtask

  initial begin
    ifa.s_valid_f = 0; ifa.s_valid_x = 0; ifa.s_data_f = '0; ifa.s_data_x = '0; ifa.m_ready_y = 1;
    ifb.s_valid_f = 0; ifb.s_valid_x = 0; ifb.s_data_f = '0; ifb.s_data_x = '0; ifb.m_ready_y = 1;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 0;
    ifa.s_valid_x = 1; ifb.s_valid_x = 1;
    repeat (3) begin
      @(negedge clk);
      chk("nofilter_xready_a", int'(ifa.s_ready_x), 0);
      chk("nofilter_xready_b", int'(ifb.s_ready_x), 0);
      chk("idle_fready_a", int'(ifa.s_ready_f), 1);
      @(posedge clk); #1;
    end
    ifa.s_valid_x = 0; ifb.s_valid_x = 0;

    // ramp through an all-ones filter
    send(1'b1, LF, f_one, 1'b0);
    push_exp(e_t1, e_t1);
    send(1'b0, LX, x_ramp, 1'b0);
    drain();

    // positive and negative saturation
    send(1'b1, LF, f_max, 1'b0);
    push_exp(e_max, e_max);
    send(1'b0, LX, x_max, 1'b0);
    drain();
    push_exp(e_zero, e_min);
    send(1'b0, LX, x_min, 1'b0);
    drain();

    // negative results: clamped on A, passed on B
    send(1'b1, LF, f_neg, 1'b0);
    push_exp(e_zero, e_neg);
    send(1'b0, LX, x_ramp, 1'b0);
    drain();

    // reset in the middle of MAC aborts the vector and forgets the filter
    send(1'b1, LF, f_one, 1'b0);
    send(1'b0, LX, x_ramp, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    reset = 0;
    ifa.s_valid_x = 1; ifb.s_valid_x = 1;
    repeat (4) begin
      @(negedge clk);
      chk("postreset_xready_a", int'(ifa.s_ready_x), 0);
      chk("postreset_xready_b", int'(ifb.s_ready_x), 0);
      @(posedge clk); #1;
    end
    ifa.s_valid_x = 0; ifb.s_valid_x = 0;
    send(1'b1, LF, f_one, 1'b0);
    push_exp(e_t1, e_t1);
    send(1'b0, LX, x_ramp, 1'b0);
    drain();

    // random traffic with back-pressure, filter reloaded every 10 vectors
    rnd_ready = 1;
    for (int v = 0; v < 200; v++) begin
      if (v % 10 == 0) begin
        for (int i = 0; i < 8; i++) fr[i] = (i < LF) ? int'($urandom_range(0, 255)) - 128 : 0;
        send(1'b1, LF, fr, 1'b1);
      end
      for (int i = 0; i < 8; i++) xr[i] = int'($urandom_range(0, 255)) - 128;
      push_model(fr, xr);
      send(1'b0, LX, xr, 1'b1);
    end
    drain();
    rnd_ready = 0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule
